// File: rtl/lcd_timing_pattern_gen_if.sv
// Pixel-side bundle of the LCD timing/pattern generator: pixel enable and pattern
// controls in, panel timing, colour and raster position out.
interface lcd_timing_pattern_gen_if;
  logic        ce;
  logic [1:0]  mode;
  logic [15:0] solid_rgb;
  logic        lcd_de;
  logic        lcd_hsync;
  logic        lcd_vsync;
  logic [4:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [4:0]  lcd_b;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        frame_start;

  modport master (
    output ce, mode, solid_rgb,
    input  lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b, pix_x, pix_y, frame_start
  );

  modport slave (
    input  ce, mode, solid_rgb,
    output lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b, pix_x, pix_y, frame_start
  );
endinterface

// File: rtl/lcd_timing_pattern_gen.sv
// RGB565 LCD timing generator with a built-in test-pattern engine (bars, grid,
// gradient, solid). All outputs are registered one CE after the raster position they describe.
module lcd_timing_pattern_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 32,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int GRID     = 32
) (
  input  logic                      clk,
  input  logic                      Reset_Button,
  lcd_timing_pattern_gen_if.slave   bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] H_ACT_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] BAR_LAST   = 11'(BAR_W - 1);
  localparam logic [10:0] GX_LAST    = 11'(GRID - 1);

  localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]  V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  GY_LAST    = 10'(GRID - 1);

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_GRID  = 2'd1;
  localparam logic [1:0] MODE_GRAD  = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  // Raster position and pattern sub-counters
  logic [10:0] h_q;
  logic [9:0]  v_q;
  logic [10:0] gx_q;
  logic [9:0]  gy_q;
  logic [10:0] bar_cnt_q;
  logic [2:0]  bar_idx_q;
  logic [1:0]  mode_q;

  // Registered panel outputs
  logic        de_q;
  logic        hs_q;
  logic        vs_q;
  logic        fs_q;
  logic [15:0] rgb_q;
  logic [10:0] px_q;
  logic [9:0]  py_q;

  logic        de_d;
  logic        hs_d;
  logic        vs_d;
  logic        grid_on;
  logic [15:0] pat;
  logic [15:0] rgb_d;
  logic        h_wrap;
  logic        v_wrap;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default up front so no path can infer a latch.
    pat     = '0;
    h_wrap  = (h_q == H_LAST);
    v_wrap  = (v_q == V_LAST);
    de_d    = (h_q < H_ACT) && (v_q < V_ACT);
    hs_d    = (h_q >= HS_START && h_q < HS_END) ? HS_POL : ~HS_POL;
    vs_d    = (v_q >= VS_START && v_q < VS_END) ? VS_POL : ~VS_POL;
    grid_on = (gx_q == '0) || (gy_q == '0) || (h_q == H_ACT_LAST) || (v_q == V_ACT_LAST);
    case (mode_q)
      MODE_BARS:  pat = bar_colour(bar_idx_q);
      MODE_GRID:  pat = grid_on ? 16'hFFFF : 16'h0000;
      MODE_GRAD:  pat = {h_q[7:3], h_q[7:2], v_q[7:3]};
      MODE_SOLID: pat = bus.solid_rgb;
      default:    pat = '0;
    endcase
    rgb_d = de_d ? pat : 16'h0000;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (Reset_Button) begin
      h_q       <= '0;
      v_q       <= '0;
      gx_q      <= '0;
      gy_q      <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      mode_q    <= bus.mode;
      de_q      <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      fs_q      <= 1'b0;
      rgb_q     <= '0;
      px_q      <= '0;
      py_q      <= '0;
    end else if (bus.ce) begin
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= (h_q == '0) && (v_q == '0);
      rgb_q <= rgb_d;
      px_q  <= h_q;
      py_q  <= v_q;

      if (h_wrap) begin
        h_q       <= '0;
        gx_q      <= '0;
        bar_cnt_q <= '0;
        bar_idx_q <= '0;
        if (v_wrap) begin
          v_q    <= '0;
          gy_q   <= '0;
          // Pattern changes only land on a frame boundary
          mode_q <= bus.mode;
        end else begin
          v_q  <= v_q + 10'd1;
          gy_q <= (gy_q == GY_LAST) ? 10'd0 : gy_q + 10'd1;
        end
      end else begin
        h_q  <= h_q + 11'd1;
        gx_q <= (gx_q == GX_LAST) ? 11'd0 : gx_q + 11'd1;
        // Bar index saturates at 7 so any remainder pixels stay black
        if (bar_cnt_q == BAR_LAST) begin
          bar_cnt_q <= '0;
          if (bar_idx_q != 3'd7) bar_idx_q <= bar_idx_q + 3'd1;
        end else begin
          bar_cnt_q <= bar_cnt_q + 11'd1;
        end
      end
    end
  end

  assign bus.lcd_de      = de_q;
  assign bus.lcd_hsync   = hs_q;
  assign bus.lcd_vsync   = vs_q;
  assign bus.frame_start = fs_q;
  assign bus.lcd_r       = rgb_q[15:11];
  assign bus.lcd_g       = rgb_q[10:5];
  assign bus.lcd_b       = rgb_q[4:0];
  assign bus.pix_x       = px_q;
  assign bus.pix_y       = py_q;

endmodule
